irq_ctrl: RTL and testbench

- Controller for the cartridge /IRQ line; arbitrates up to 8 mapper IRQ requesters:
  - scanline counter (A12 based)
  - CPU cycle counter
  - expansion audio
  - others
- Each requester has an enable mask, a pending latch, edge/level mode and CPU write-1-to-clear acknowledge.
- The IRQ output is sequenced to CPU M2 falling edges, with a guaranteed minimum deassert gap.
- Sits between the per-mapper IRQ counters and the cart IRQ pin; participates in save-state.

---
 rtl/irq_ctrl_pkg.sv | 34 +++
 rtl/m2_edge.sv | 37 +++
 rtl/irq_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_irq_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared constants, save-state bus type and helpers for the cartridge IRQ controller.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_IDLE   = 2'd0;
    localparam logic [1:0] IRQ_ASSERT = 2'd1;
    localparam logic [1:0] IRQ_GAP    = 2'd2;

    localparam logic [3:0] REG_MASK = 4'h8;
    localparam logic [3:0] REG_ACK  = 4'h9;
    localparam logic [3:0] REG_MODE = 4'hA;

    localparam logic [7:0] SST_MASK = 8'd24;
    localparam logic [7:0] SST_MODE = 8'd25;
    localparam logic [7:0] SST_PEND = 8'd26;
    localparam logic [7:0] SST_FSM  = 8'd27;

    typedef struct packed {
        logic       act;
        logic       we_reg;
        logic [7:0] addr;
        logic [7:0] data;
    } sst_bus_t;

    // Lowest set bit index; 0 when no bit is set.
    function automatic logic [2:0] first_set(input logic [7:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            idx = bits[i] ? 3'(i) : idx;
        end
        return idx;
    endfunction

endpackage

// File: rtl/m2_edge.sv
// Two-flop synchroniser for CPU M2 with a registered one-clk falling-edge pulse.
module m2_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic srst,
    input  logic m2,
    output logic fe
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic fe_r;

    // Synchronise M2 and flag a 1->0 transition of the stable copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            fe_r    <= 1'b0;
        end else if (srst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            fe_r    <= 1'b0;
        end else begin
            sync1_r <= m2;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            fe_r    <= prev_r & ~sync2_r;
        end
    end

    assign fe = fe_r;

endmodule

// File: rtl/irq_ctrl.sv
// Cartridge /IRQ arbiter: per-requester mask/pending/mode, W1C acknowledge,
// M2-sequenced output with minimum deassert gap, and save-state access.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int SRC_N  = 4,
    parameter int GAP_M2 = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             map_rst,
    input  logic             cpu_m2,
    input  logic             decode_en,
    input  logic [3:0]       reg_addr,
    input  logic [7:0]       cpu_data,
    input  logic [SRC_N-1:0] src_irq,
    output logic [SRC_N-1:0] src_ack,
    output logic             irq,
    output logic [2:0]       irq_src,
    output logic [7:0]       status,
    input  sst_bus_t         sst,
    output logic [7:0]       sst_di
);

    localparam logic [2:0] GAP_INIT = 3'(GAP_M2);

    logic             m2_fe_s;
    logic [SRC_N-1:0] mask_r, mode_r, pend_r, src_prev_r, src_ack_r;
    logic [1:0]       state_r;
    logic [2:0]       gap_r;
    logic             irq_r;
    logic [2:0]       irq_src_r;
    logic [7:0]       sst_di_r;

    logic [SRC_N-1:0] pend_nxt_s, ack_bits_s, hit_s;
    logic             active_s;
    logic             wr_mask_s, wr_mode_s;
    logic [1:0]       state_nxt_s;
    logic [2:0]       gap_nxt_s;
    logic [7:0]       pend_ext_s, mask_ext_s, mode_ext_s, hit_ext_s, readback_s;
    logic             unused_bits_s;

    m2_edge u_m2_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .srst  (1'b0),
        .m2    (cpu_m2),
        .fe    (m2_fe_s)
    );

    assign hit_s      = pend_r & mask_r;
    assign active_s   = |hit_s;
    assign wr_mask_s  = decode_en && (reg_addr == REG_MASK);
    assign wr_mode_s  = decode_en && (reg_addr == REG_MODE);
    assign ack_bits_s = (decode_en && (reg_addr == REG_ACK)) ? cpu_data[SRC_N-1:0] : {SRC_N{1'b0}};
    assign unused_bits_s = ^{cpu_data, sst.data};

    // Zero-extend the per-requester vectors to the 8-bit CPU/save-state view.
    always_comb begin
        pend_ext_s = 8'h00;
        mask_ext_s = 8'h00;
        mode_ext_s = 8'h00;
        hit_ext_s  = 8'h00;
        for (int i = 0; i < SRC_N; i++) begin
            pend_ext_s[i] = pend_r[i];
            mask_ext_s[i] = mask_r[i];
            mode_ext_s[i] = mode_r[i];
            hit_ext_s[i]  = hit_s[i];
        end
    end

    // Pending latch: a fresh edge beats a same-clk acknowledge; level mode tracks the input.
    always_comb begin
        pend_nxt_s = pend_r;
        for (int i = 0; i < SRC_N; i++) begin
            if (mode_r[i]) begin
                pend_nxt_s[i] = src_irq[i];
            end else if (src_irq[i] && !src_prev_r[i]) begin
                pend_nxt_s[i] = 1'b1;
            end else if (ack_bits_s[i]) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pend_r[i];
            end
        end
    end

    // Output sequencer; deassert is immediate, everything else waits for M2 falling edges.
    always_comb begin
        state_nxt_s = state_r;
        gap_nxt_s   = gap_r;
        case (state_r)
            IRQ_IDLE: begin
                if (m2_fe_s && active_s) begin
                    state_nxt_s = IRQ_ASSERT;
                end else begin
                    state_nxt_s = IRQ_IDLE;
                end
            end
            IRQ_ASSERT: begin
                if (!active_s) begin
                    state_nxt_s = IRQ_GAP;
                    gap_nxt_s   = GAP_INIT;
                end else begin
                    state_nxt_s = IRQ_ASSERT;
                end
            end
            IRQ_GAP: begin
                if (m2_fe_s) begin
                    if (gap_r <= 3'd1) begin
                        state_nxt_s = IRQ_IDLE;
                        gap_nxt_s   = 3'd0;
                    end else begin
                        gap_nxt_s   = gap_r - 3'd1;
                    end
                end else begin
                    state_nxt_s = IRQ_GAP;
                end
            end
            default: begin
                state_nxt_s = IRQ_IDLE;
                gap_nxt_s   = 3'd0;
            end
        endcase
    end

    // Save-state readback mux.
    always_comb begin
        case (sst.addr)
            SST_MASK: readback_s = mask_ext_s;
            SST_MODE: readback_s = mode_ext_s;
            SST_PEND: readback_s = pend_ext_s;
            SST_FSM:  readback_s = {3'b000, gap_r, state_r};
            default:  readback_s = 8'hff;
        endcase
    end

    // Edge detectors always follow the inputs so a restore never sees a stale edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_prev_r <= {SRC_N{1'b0}};
        end else begin
            src_prev_r <= src_irq;
        end
    end

    // Save-state readback register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sst_di_r <= 8'h00;
        end else begin
            sst_di_r <= readback_s;
        end
    end

    // Controller state: save-state freeze/restore, then mapper reset, then normal operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r    <= {SRC_N{1'b0}};
            mode_r    <= {SRC_N{1'b0}};
            pend_r    <= {SRC_N{1'b0}};
            src_ack_r <= {SRC_N{1'b0}};
            state_r   <= IRQ_IDLE;
            gap_r     <= 3'd0;
            irq_r     <= 1'b0;
            irq_src_r <= 3'd0;
        end else if (sst.act) begin
            src_ack_r <= {SRC_N{1'b0}};
            if (sst.we_reg) begin
                case (sst.addr)
                    SST_MASK: mask_r <= sst.data[SRC_N-1:0];
                    SST_MODE: mode_r <= sst.data[SRC_N-1:0];
                    SST_PEND: pend_r <= sst.data[SRC_N-1:0];
                    SST_FSM: begin
                        gap_r   <= sst.data[4:2];
                        state_r <= sst.data[1:0];
                    end
                    default: begin
                    end
                endcase
            end else begin
                mask_r <= mask_r;
            end
        end else if (map_rst) begin
            mask_r    <= {SRC_N{1'b0}};
            pend_r    <= {SRC_N{1'b0}};
            src_ack_r <= {SRC_N{1'b0}};
            state_r   <= IRQ_IDLE;
            gap_r     <= 3'd0;
            irq_r     <= 1'b0;
            irq_src_r <= 3'd0;
        end else begin
            pend_r    <= pend_nxt_s;
            src_ack_r <= ack_bits_s;
            state_r   <= state_nxt_s;
            gap_r     <= gap_nxt_s;
            irq_r     <= (state_nxt_s == IRQ_ASSERT);
            irq_src_r <= first_set(hit_ext_s);
            if (wr_mask_s) begin
                mask_r <= cpu_data[SRC_N-1:0];
            end else begin
                mask_r <= mask_r;
            end
            if (wr_mode_s) begin
                mode_r <= cpu_data[SRC_N-1:0];
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    assign src_ack = src_ack_r;
    assign irq     = irq_r;
    assign irq_src = irq_src_r;
    assign status  = pend_ext_s;
    assign sst_di  = sst_di_r;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// compared every clock against a behavioural model of the controller.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int SRC_N  = 4;
    localparam int GAP_M2 = 2;

    logic       clk;
    logic       rst_n;
    logic       map_rst;
    logic       cpu_m2;
    logic       decode_en;
    logic [3:0] reg_addr;
    logic [7:0] cpu_data;
    logic [3:0] src_irq;
    logic [3:0] src_ack;
    logic       irq;
    logic [2:0] irq_src;
    logic [7:0] status;
    sst_bus_t   sst;
    logic [7:0] sst_di;

    int checks = 0;
    int failures = 0;

    irq_ctrl #(.SRC_N(SRC_N), .GAP_M2(GAP_M2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .map_rst   (map_rst),
        .cpu_m2    (cpu_m2),
        .decode_en (decode_en),
        .reg_addr  (reg_addr),
        .cpu_data  (cpu_data),
        .src_irq   (src_irq),
        .src_ack   (src_ack),
        .irq       (irq),
        .irq_src   (irq_src),
        .status    (status),
        .sst       (sst),
        .sst_di    (sst_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // M2 runs freely, asynchronous in spirit: random half periods of 2..5 clk.
    initial begin
        cpu_m2 = 1'b1;
        forever begin
            repeat ($urandom_range(2, 5)) @(negedge clk);
            cpu_m2 = ~cpu_m2;
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0] m_mask, m_mode, m_pend, m_prev, m_ack;
    logic [1:0] m_state;   // 0 idle, 1 asserting, 2 gap
    logic [2:0] m_gap;
    logic       m_irq;
    logic [2:0] m_src;
    logic [7:0] m_sst_di;
    logic       m_hist [0:3];   // past M2 samples, newest first

    function automatic logic [2:0] lowest(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic [7:0] peek(input logic [7:0] a);
        case (a)
            8'd24:   return {4'h0, m_mask};
            8'd25:   return {4'h0, m_mode};
            8'd26:   return {4'h0, m_pend};
            8'd27:   return {3'b000, m_gap, m_state};
            default: return 8'hff;
        endcase
    endfunction

    task automatic model_step();
        logic       fe, any_hit;
        logic [3:0] hit, ackb, np;
        if (!rst_n) begin
            m_mask = 4'h0; m_mode = 4'h0; m_pend = 4'h0; m_prev = 4'h0; m_ack = 4'h0;
            m_state = 2'd0; m_gap = 3'd0; m_irq = 1'b0; m_src = 3'd0; m_sst_di = 8'h00;
            for (int i = 0; i < 4; i++) m_hist[i] = 1'b0;
        end else begin
            // a falling edge of M2 seen 4..3 edges ago reaches the sequencer now
            fe = m_hist[3] & ~m_hist[2];
            m_hist[3] = m_hist[2]; m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = cpu_m2;
            m_sst_di = peek(sst.addr);
            if (sst.act) begin
                m_ack = 4'h0;
                if (sst.we_reg) begin
                    case (sst.addr)
                        8'd24: m_mask = sst.data[3:0];
                        8'd25: m_mode = sst.data[3:0];
                        8'd26: m_pend = sst.data[3:0];
                        8'd27: begin m_gap = sst.data[4:2]; m_state = sst.data[1:0]; end
                        default: ;
                    endcase
                end
            end else if (map_rst) begin
                m_mask = 4'h0; m_pend = 4'h0; m_ack = 4'h0;
                m_state = 2'd0; m_gap = 3'd0; m_irq = 1'b0; m_src = 3'd0;
            end else begin
                hit = m_pend & m_mask;
                any_hit = |hit;
                ackb = (decode_en && reg_addr == 4'h9) ? cpu_data[3:0] : 4'h0;
                for (int i = 0; i < 4; i++) begin
                    if (m_mode[i]) np[i] = src_irq[i];
                    else if (src_irq[i] && !m_prev[i]) np[i] = 1'b1;
                    else if (ackb[i]) np[i] = 1'b0;
                    else np[i] = m_pend[i];
                end
                case (m_state)
                    2'd0: if (fe && any_hit) m_state = 2'd1;
                    2'd1: if (!any_hit) begin m_state = 2'd2; m_gap = 3'(GAP_M2); end
                    2'd2: if (fe) begin
                        if (m_gap <= 3'd1) begin m_state = 2'd0; m_gap = 3'd0; end
                        else m_gap = m_gap - 3'd1;
                    end
                    default: begin m_state = 2'd0; m_gap = 3'd0; end
                endcase
                m_irq = (m_state == 2'd1);
                m_src = lowest(hit);
                m_ack = ackb;
                m_pend = np;
                if (decode_en && reg_addr == 4'h8) m_mask = cpu_data[3:0];
                if (decode_en && reg_addr == 4'hA) m_mode = cpu_data[3:0];
            end
            m_prev = src_irq;
        end
    endtask

    // Single compare process: every clock, just after the edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #1;
            chk("model_irq", {7'd0, irq}, {7'd0, m_irq});
            chk("model_irq_src", {5'd0, irq_src}, {5'd0, m_src});
            chk("model_src_ack", {4'd0, src_ack}, {4'd0, m_ack});
            chk("model_status", status, {4'd0, m_pend});
            chk("model_sst_di", sst_di, m_sst_di);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        decode_en = 1'b1; reg_addr = a; cpu_data = d;
        @(negedge clk);
        decode_en = 1'b0;
    endtask

    task automatic pulse(input int i);
        src_irq[i] = 1'b1;
        @(negedge clk);
        src_irq[i] = 1'b0;
    endtask

    task automatic wait_irq(input logic val, input int budget, input string name);
        int n = 0;
        while (irq !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {7'd0, irq}, {7'd0, val});
    endtask

    initial begin
        int sst_left = 0;
        logic [7:0] d;
        rst_n = 1'b0; map_rst = 1'b0; decode_en = 1'b0; reg_addr = 4'h0;
        cpu_data = 8'h00; src_irq = 4'h0; sst = '0;
        repeat (3) @(negedge clk);
        chk("reset_irq", {7'd0, irq}, 8'h00);
        chk("reset_irq_src", {5'd0, irq_src}, 8'h00);
        chk("reset_status", status, 8'h00);
        chk("reset_src_ack", {4'd0, src_ack}, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // edge requester, ack and drop
        wr(4'h8, 8'h01);
        pulse(0);
        wait_irq(1'b1, 60, "edge_irq_rise");
        chk("edge_irq_src", {5'd0, irq_src}, 8'h00);
        chk("edge_status", status, 8'h01);
        decode_en = 1'b1; reg_addr = 4'h9; cpu_data = 8'h01;
        @(negedge clk);
        decode_en = 1'b0;
        chk("ack_pulse", {4'd0, src_ack}, 8'h01);
        @(negedge clk);
        chk("ack_pulse_end", {4'd0, src_ack}, 8'h00);
        chk("ack_irq_drop", {7'd0, irq}, 8'h00);

        // edge set colliding with ack: set wins
        pulse(0);
        wait_irq(1'b1, 60, "collide_irq_rise");
        src_irq[0] = 1'b1; decode_en = 1'b1; reg_addr = 4'h9; cpu_data = 8'h01;
        @(negedge clk);
        decode_en = 1'b0;
        chk("collide_ack", {4'd0, src_ack}, 8'h01);
        repeat (2) @(negedge clk);
        chk("collide_pend", status, 8'h01);
        chk("collide_irq", {7'd0, irq}, 8'h01);
        src_irq[0] = 1'b0;
        wr(4'h9, 8'h01);
        wait_irq(1'b0, 10, "collide_irq_drop");

        // priority between requesters 1 and 2
        wr(4'h8, 8'h06);
        pulse(2);
        wait_irq(1'b1, 60, "prio_irq_rise");
        repeat (2) @(negedge clk);
        chk("prio_src2", {5'd0, irq_src}, 8'h02);
        pulse(1);
        repeat (2) @(negedge clk);
        chk("prio_src1", {5'd0, irq_src}, 8'h01);
        wr(4'h9, 8'h02);
        repeat (2) @(negedge clk);
        chk("prio_back_to2", {5'd0, irq_src}, 8'h02);
        chk("prio_irq_held", {7'd0, irq}, 8'h01);
        wr(4'h9, 8'h04);
        wait_irq(1'b0, 10, "prio_irq_drop");

        // masked requester latches but cannot drive irq
        wr(4'h8, 8'h00);
        pulse(3);
        repeat (2) @(negedge clk);
        chk("masked_status", status, 8'h08);
        repeat (20) @(negedge clk);
        chk("masked_no_irq", {7'd0, irq}, 8'h00);
        wr(4'h8, 8'h08);
        wait_irq(1'b1, 60, "unmask_irq_rise");
        wr(4'h9, 8'h08);
        wait_irq(1'b0, 10, "unmask_irq_drop");

        // level mode and the deassert gap
        wr(4'h8, 8'h01);
        wr(4'hA, 8'h01);
        src_irq[0] = 1'b1;
        wait_irq(1'b1, 60, "level_irq_rise");
        src_irq[0] = 1'b0;
        repeat (2) @(negedge clk);
        chk("level_irq_drop", {7'd0, irq}, 8'h00);
        src_irq[0] = 1'b1;
        repeat (5) @(negedge clk);
        chk("level_gap_held", {7'd0, irq}, 8'h00);
        wait_irq(1'b1, 60, "level_irq_again");
        wr(4'hA, 8'h00);
        src_irq[0] = 1'b0;
        wr(4'h9, 8'h01);
        wait_irq(1'b0, 10, "level_clean");

        // async reset while asserting
        pulse(0);
        wait_irq(1'b1, 60, "rst_irq_rise");
        rst_n = 1'b0;
        #1;
        chk("rst_irq_now", {7'd0, irq}, 8'h00);
        chk("rst_status_now", status, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // save-state restore into ASSERT
        sst.act = 1'b1; sst.we_reg = 1'b1; sst.addr = 8'd24; sst.data = 8'h01;
        @(negedge clk);
        sst.addr = 8'd26; sst.data = 8'h01;
        @(negedge clk);
        sst.addr = 8'd27; sst.data = {3'd0, IRQ_ASSERT};
        @(negedge clk);
        sst.we_reg = 1'b0; sst.addr = 8'd26;
        @(negedge clk);
        chk("sst_read_pend", sst_di, 8'h01);
        chk("sst_irq_frozen", {7'd0, irq}, 8'h00);
        sst.addr = 8'd30;
        @(negedge clk);
        chk("sst_read_other", sst_di, 8'hff);
        sst.act = 1'b0;
        @(negedge clk);
        chk("sst_irq_restored", {7'd0, irq}, 8'h01);
        wr(4'h9, 8'h01);
        wait_irq(1'b0, 10, "sst_clean");

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 7) == 0) src_irq[i] = ~src_irq[i];
            end
            decode_en = ($urandom_range(0, 4) == 0);
            case ($urandom_range(0, 3))
                0: reg_addr = 4'h8;
                1: reg_addr = 4'h9;
                2: reg_addr = 4'hA;
                default: reg_addr = 4'($urandom_range(0, 15));
            endcase
            cpu_data = 8'($urandom);
            map_rst = ($urandom_range(0, 149) == 0);
            if (sst_left > 0) begin
                d = 8'($urandom);
                sst.act = 1'b1;
                sst.we_reg = 1'($urandom_range(0, 1));
                sst.addr = 8'(22 + $urandom_range(0, 9));
                if (sst.addr == 8'd27) d[1:0] = 2'($urandom_range(0, 2));
                sst.data = d;
                sst_left--;
            end else begin
                sst.act = 1'b0;
                sst.we_reg = 1'b0;
                sst.addr = 8'(22 + $urandom_range(0, 9));
                if ($urandom_range(0, 199) == 0) sst_left = $urandom_range(2, 6);
            end
        end
        @(negedge clk);
        decode_en = 1'b0; map_rst = 1'b0; sst = '0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
